// File: rtl/systolic_array_pkg.sv
// rtl/systolic_array_pkg.sv - shared types and defaults for the systolic-array tile scheduler
package systolic_array_pkg;

    localparam int SA_DEFAULT_TILE_DIM     = 2;
    localparam int SA_DEFAULT_DRAIN_CYCLES = 2 * SA_DEFAULT_TILE_DIM;
    localparam int SA_NUM_STATES           = 9;

    // Bit positions of the one-hot scheduler states.
    typedef enum int unsigned {
        IDLE_B    = 0,
        LOAD_B    = 1,
        ISSUE_B   = 2,
        FEED_B    = 3,
        DRAIN_B   = 4,
        WB_B      = 5,
        WB_WAIT_B = 6,
        NEXT_B    = 7,
        FINI_B    = 8
    } sa_sched_state_b_t;

    typedef enum logic [SA_NUM_STATES-1:0] {
        S_IDLE    = 9'(1 << IDLE_B),
        S_LOAD    = 9'(1 << LOAD_B),
        S_ISSUE   = 9'(1 << ISSUE_B),
        S_FEED    = 9'(1 << FEED_B),
        S_DRAIN   = 9'(1 << DRAIN_B),
        S_WB      = 9'(1 << WB_B),
        S_WB_WAIT = 9'(1 << WB_WAIT_B),
        S_NEXT    = 9'(1 << NEXT_B),
        S_FINI    = 9'(1 << FINI_B)
    } sa_sched_state_t;

    // ceil(a/d) without forming a+d-1, so dimensions near 2^32 do not wrap.
    function automatic logic [31:0] sa_ceil_div(input logic [31:0] a, input int unsigned d);
        return (a / 32'(d)) + {31'd0, ((a % 32'(d)) != 32'd0)};
    endfunction

endpackage

// File: rtl/sa_tile_index_counter.sv
// rtl/sa_tile_index_counter.sv - row-major tile index walker with latched tile counts
// Ports: i_clear latches tile counts from i_m/i_n and zeroes indices; i_advance steps
// column-innermost; o_last flags the final tile. Indices never wrap past the last tile.
module sa_tile_index_counter
    import systolic_array_pkg::*;
#(
    parameter int TILE_DIM = SA_DEFAULT_TILE_DIM
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_advance,
    input  logic [31:0] i_m,
    input  logic [31:0] i_n,
    output logic [31:0] o_blk_row_idx,
    output logic [31:0] o_blk_col_idx,
    output logic        o_last
);

    logic [31:0] r_rt;
    logic [31:0] r_ct;
    logic [31:0] r_row;
    logic [31:0] r_col;
    logic        w_last;
    logic        w_col_wrap;

    assign w_col_wrap = (r_col == r_ct - 32'd1);
    assign w_last     = (r_row == r_rt - 32'd1) && w_col_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rt  <= '0;
            r_ct  <= '0;
            r_row <= '0;
            r_col <= '0;
        end else if (i_clear) begin
            r_rt  <= sa_ceil_div(i_m, TILE_DIM);
            r_ct  <= sa_ceil_div(i_n, TILE_DIM);
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance && !w_last) begin
            // Final indices are held so the last tile stays visible after done.
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= r_row + 32'd1;
            end else begin
                r_col <= r_col + 32'd1;
            end
        end
    end

    assign o_blk_row_idx = r_row;
    assign o_blk_col_idx = r_col;
    assign o_last        = w_last;

endmodule

// File: rtl/sa_tile_scheduler.sv
// rtl/sa_tile_scheduler.sv - sequences systolic-array output tiles through feed, drain and writeback
// Ports: start/done/err/busy to the top FSM; tile_start + row/col base addresses and
// feed_done with the FIFO datapaths; wb_start/wb_done with the output writer;
// blk_row_idx/blk_col_idx name the tile in flight.
module sa_tile_scheduler
    import systolic_array_pkg::*;
#(
    parameter int TILE_DIM     = SA_DEFAULT_TILE_DIM,
    parameter int ADDR_WIDTH   = 16,
    parameter int DRAIN_CYCLES = 2 * TILE_DIM
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           M,
    input  logic [31:0]           N,
    input  logic [31:0]           K,
    output logic                  tile_start,
    output logic [ADDR_WIDTH-1:0] row_base_addr,
    output logic [ADDR_WIDTH-1:0] col_base_addr,
    input  logic                  feed_done,
    output logic                  wb_start,
    input  logic                  wb_done,
    output logic [31:0]           blk_row_idx,
    output logic [31:0]           blk_col_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    sa_sched_state_t r_state;
    sa_sched_state_t w_next;

    logic [31:0] r_k;
    logic [31:0] r_drain_cnt;
    logic        r_err;
    logic        w_zero_dim;
    logic        w_last;
    logic [31:0] w_row_idx;
    logic [31:0] w_col_idx;

    assign w_zero_dim = (M == 32'd0) || (N == 32'd0) || (K == 32'd0);

    sa_tile_index_counter #(
        .TILE_DIM (TILE_DIM)
    ) u_index (
        .clk           (clk),
        .rst           (rst),
        .i_clear       (r_state == S_LOAD),
        .i_advance     (r_state == S_NEXT),
        .i_m           (M),
        .i_n           (N),
        .o_blk_row_idx (w_row_idx),
        .o_blk_col_idx (w_col_idx),
        .o_last        (w_last)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; any non one-hot encoding falls to IDLE.
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:    w_next = start ? S_LOAD : S_IDLE;
            S_LOAD:    w_next = w_zero_dim ? S_FINI : S_ISSUE;
            S_ISSUE:   w_next = S_FEED;
            S_FEED:    w_next = feed_done ? S_DRAIN : S_FEED;
            S_DRAIN:   w_next = (r_drain_cnt == 32'd0) ? S_WB : S_DRAIN;
            S_WB:      w_next = S_WB_WAIT;
            S_WB_WAIT: w_next = wb_done ? S_NEXT : S_WB_WAIT;
            S_NEXT:    w_next = w_last ? S_FINI : S_ISSUE;
            S_FINI:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Latched K, drain countdown and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k         <= '0;
            r_drain_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_err <= 1'b0;
            end
            if (r_state == S_LOAD) begin
                r_k   <= K;
                r_err <= w_zero_dim;
            end
            // Loaded with DRAIN_CYCLES-1 so that exactly DRAIN_CYCLES cycles are spent draining.
            if (r_state == S_FEED && feed_done) begin
                r_drain_cnt <= 32'(DRAIN_CYCLES - 1);
            end else if (r_state == S_DRAIN && r_drain_cnt != 32'd0) begin
                r_drain_cnt <= r_drain_cnt - 32'd1;
            end
        end
    end

    // Moore outputs
    always_comb begin
        tile_start = 1'b0;
        wb_start   = 1'b0;
        done       = 1'b0;
        busy       = 1'b1;
        case (r_state)
            S_IDLE:  busy       = 1'b0;
            S_ISSUE: tile_start = 1'b1;
            S_WB:    wb_start   = 1'b1;
            S_FINI:  done       = 1'b1;
            default: busy       = 1'b1;
        endcase
    end

    assign err         = r_err;
    assign blk_row_idx = w_row_idx;
    assign blk_col_idx = w_col_idx;

    // 32-bit products truncated to the buffer address width; overflow wraps silently.
    assign row_base_addr = ADDR_WIDTH'(w_row_idx * 32'(TILE_DIM) * r_k);
    assign col_base_addr = ADDR_WIDTH'(w_col_idx * 32'(TILE_DIM) * r_k);

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// tb/tb_sa_tile_scheduler.sv - self-checking bench for sa_tile_scheduler
module tb_sa_tile_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] M = '0;
    logic [31:0] N = '0;
    logic [31:0] K = '0;
    logic        feed_done = 1'b0;
    logic        wb_done = 1'b0;
    logic        tile_start;
    logic [15:0] row_base_addr;
    logic [15:0] col_base_addr;
    logic        wb_start;
    logic [31:0] blk_row_idx;
    logic [31:0] blk_col_idx;
    logic        busy;
    logic        done;
    logic        err;

    sa_tile_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .M             (M),
        .N             (N),
        .K             (K),
        .tile_start    (tile_start),
        .row_base_addr (row_base_addr),
        .col_base_addr (col_base_addr),
        .feed_done     (feed_done),
        .wb_start      (wb_start),
        .wb_done       (wb_done),
        .blk_row_idx   (blk_row_idx),
        .blk_col_idx   (blk_col_idx),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] c;
        logic [15:0] rb;
        logic [15:0] cb;
    } tile_t;

    tile_t       exp_q[$];
    tile_t       cur;
    logic [15:0] obs_rb[$];
    logic [15:0] obs_cb[$];
    int          ts_cnt = 0;
    int          wb_cnt = 0;
    int          done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected tile sequence straight from the tiling rule: row-major, ceil division, base = idx*2*K.
    task automatic load_model(input int m, input int n, input int k);
        int rt;
        int ct;
        tile_t t;
        rt = (m + 1) / 2;
        ct = (n + 1) / 2;
        exp_q.delete();
        obs_rb.delete();
        obs_cb.delete();
        if (m != 0 && n != 0 && k != 0) begin
            for (int r = 0; r < rt; r++) begin
                for (int c = 0; c < ct; c++) begin
                    t.r  = 32'(r);
                    t.c  = 32'(c);
                    t.rb = 16'(r * 2 * k);
                    t.cb = 16'(c * 2 * k);
                    exp_q.push_back(t);
                end
            end
        end
    endtask

    // Compare process: every tile_start, wb_start and done is checked against the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (tile_start) begin
                ts_cnt++;
                obs_rb.push_back(row_base_addr);
                obs_cb.push_back(col_base_addr);
                if (exp_q.size() == 0) begin
                    check("tile_start_unexpected", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("tile_row_idx", blk_row_idx, cur.r);
                    check("tile_col_idx", blk_col_idx, cur.c);
                    check("row_base_addr", row_base_addr, cur.rb);
                    check("col_base_addr", col_base_addr, cur.cb);
                end
            end
            if (wb_start) begin
                wb_cnt++;
                check("wb_row_idx", blk_row_idx, cur.r);
                check("wb_col_idx", blk_col_idx, cur.c);
            end
            if (done) begin
                done_cnt++;
                check("done_tiles_left", exp_q.size(), 0);
            end
        end
    end

    function automatic logic sig(input int sel);
        case (sel)
            0:       return tile_start;
            1:       return wb_start;
            default: return done;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input string name);
        int n;
        n = 0;
        while (!sig(sel) && n < 200) begin
            tick();
            n++;
        end
        if (!sig(sel)) check(name, 0, 1);
    endtask

    task automatic run_mm(input int m, input int n, input int k, input bit noise, input bit hold_wb);
        int ts0;
        int wb0;
        int d0;
        int fc;
        int ntiles;
        ts0 = ts_cnt;
        wb0 = wb_cnt;
        d0 = done_cnt;
        ntiles = ((m + 1) / 2) * ((n + 1) / 2);
        load_model(m, n, k);
        M = 32'(m);
        N = 32'(n);
        K = 32'(k);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("err_cleared_on_start", err, 0);
        tick();
        // Dimensions are latched; later changes must not affect this run.
        M = 32'd7;
        N = 32'd9;
        K = 32'd5;
        if (hold_wb) wb_done = 1'b1;
        for (int t = 0; t < ntiles; t++) begin
            wait_sig(0, "timeout_tile_start");
            if (noise) feed_done = 1'b1;
            tick();
            feed_done = 1'b0;
            if (noise) start = 1'b1;
            tick();
            start = 1'b0;
            feed_done = 1'b1;
            fc = cyc;
            tick();
            feed_done = 1'b0;
            if (noise) feed_done = 1'b1;
            tick();
            feed_done = 1'b0;
            wait_sig(1, "timeout_wb_start");
            check("wb_latency", cyc - fc, 5);
            if (!hold_wb) begin
                tick();
                wb_done = 1'b1;
                tick();
                wb_done = 1'b0;
            end else begin
                tick();
            end
        end
        wait_sig(2, "timeout_done");
        check("done_err", err, 0);
        check("tile_start_count", ts_cnt - ts0, ntiles);
        check("wb_start_count", wb_cnt - wb0, ntiles);
        tick();
        wb_done = 1'b0;
        check("done_count", done_cnt - d0, 1);
        check("idle_after_done", busy, 0);
    endtask

    int c0;
    int ts_before;
    int wb_before;
    int d_before;
    logic [15:0] exp_rb4[4];
    logic [15:0] exp_cb4[4];

    initial begin
        exp_rb4 = '{16'd0, 16'd0, 16'd6, 16'd6};
        exp_cb4 = '{16'd0, 16'd6, 16'd0, 16'd6};

        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_outputs", {tile_start, wb_start, done, err}, 0);
        rst = 1'b0;
        tick();

        // Exact timing for a single 2x2 tile.
        load_model(2, 2, 2);
        c0 = cyc;
        M = 32'd2;
        N = 32'd2;
        K = 32'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_sig(0, "timeout_t1_tile_start");
        check("t1_tile_start_cycle", cyc - c0, 2);
        check("t1_bases", {row_base_addr, col_base_addr}, 0);
        while (cyc < c0 + 5) tick();
        feed_done = 1'b1;
        tick();
        feed_done = 1'b0;
        wait_sig(1, "timeout_t1_wb_start");
        check("t1_wb_start_cycle", cyc - c0, 10);
        while (cyc < c0 + 12) tick();
        wb_done = 1'b1;
        tick();
        wb_done = 1'b0;
        wait_sig(2, "timeout_t1_done");
        check("t1_done_cycle", cyc - c0, 14);
        check("t1_err", err, 0);
        tick();

        // 2x2 tiles, K=3: bases pinned to literals.
        run_mm(4, 4, 3, 1'b0, 1'b0);
        check("t2_tiles_seen", obs_rb.size(), 4);
        for (int i = 0; i < 4 && i < obs_rb.size(); i++) begin
            check("t2_row_base_literal", obs_rb[i], exp_rb4[i]);
            check("t2_col_base_literal", obs_cb[i], exp_cb4[i]);
        end

        // Ceiling case: M=3 gives two tile rows.
        run_mm(3, 2, 1, 1'b0, 1'b0);
        check("t3_tiles_seen", obs_rb.size(), 2);
        if (obs_rb.size() == 2) begin
            check("t3_row_base0", obs_rb[0], 0);
            check("t3_row_base1", obs_rb[1], 2);
            check("t3_col_base0", obs_cb[0], 0);
            check("t3_col_base1", obs_cb[1], 0);
        end

        // K=0: immediate done with err, no tiles.
        load_model(2, 2, 0);
        ts_before = ts_cnt;
        wb_before = wb_cnt;
        c0 = cyc;
        M = 32'd2;
        N = 32'd2;
        K = 32'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_sig(2, "timeout_k0_done");
        check("k0_done_cycle", cyc - c0, 2);
        check("k0_err", err, 1);
        tick();
        check("k0_err_held", err, 1);
        check("k0_no_tile_start", ts_cnt - ts_before, 0);
        check("k0_no_wb_start", wb_cnt - wb_before, 0);
        run_mm(2, 2, 2, 1'b0, 1'b0);

        // Spurious feed_done/start ignored; wb_done held high.
        run_mm(4, 2, 2, 1'b1, 1'b0);
        run_mm(4, 4, 1, 1'b0, 1'b1);

        // Asynchronous reset while draining.
        load_model(2, 2, 2);
        d_before = done_cnt;
        M = 32'd2;
        N = 32'd2;
        K = 32'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_sig(0, "timeout_rst_tile_start");
        tick();
        tick();
        feed_done = 1'b1;
        tick();
        feed_done = 1'b0;
        tick();
        check("rst_pre_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_busy", busy, 0);
        check("rst_async_pulses", {tile_start, wb_start, done, err}, 0);
        check("rst_async_idx", {blk_row_idx, blk_col_idx}, 0);
        check("rst_async_bases", {row_base_addr, col_base_addr}, 0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_no_done", done_cnt - d_before, 0);
        run_mm(2, 2, 2, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
